// File: rtl/g_matrix_row_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | g_matrix_row_loader: run-time loadable store of QC-LDPC generator     |
// | first-rows, streamed in circulant-by-circulant. Rev 1.0               |
// +-----------------------------------------------------------------------+
module g_matrix_row_loader #(
  parameter int CIRC_SIZE    = 88,
  parameter int CIRC_PER_ROW = 16,
  parameter int NUM_ROWS     = 39
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic                              in_valid,
  input  logic [CIRC_SIZE-1:0]              in_data,
  output logic                              in_ready,
  input  logic [5:0]                        sel,
  output logic [CIRC_SIZE*CIRC_PER_ROW-1:0] out,
  output logic                              load_busy,
  output logic                              load_done
);

  localparam int c_ROW_W = CIRC_SIZE * CIRC_PER_ROW;
  localparam int c_ASM_W = c_ROW_W - CIRC_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_circ_cnt;
  logic [5:0]             r_row_cnt;
  logic                   r_load_done;
  logic [c_ASM_W-1:0]     r_asm;
  logic [c_ROW_W-1:0]     r_mem [NUM_ROWS];

  logic                   w_accept;
  logic                   w_last_circ;
  logic                   w_last_row;
  logic                   w_row_wr;
  logic [c_ROW_W-1:0]     w_full_row;

  // A restart pulse takes priority over a beat presented in the same cycle.
  assign w_accept    = !rst && !load_start && in_valid && (r_state == ST_LOAD);
  assign w_last_circ = (r_circ_cnt == 4'(CIRC_PER_ROW - 1));
  assign w_last_row  = (r_row_cnt == 6'(NUM_ROWS - 1));
  assign w_row_wr    = w_accept && w_last_circ;
  assign w_full_row  = {r_asm, in_data};

  assign in_ready  = (r_state == ST_LOAD);
  assign load_busy = (r_state == ST_LOAD);
  assign load_done = r_load_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_circ_cnt  <= 4'd0;
      r_row_cnt   <= 6'd0;
      r_load_done <= 1'b0;
    end else if (load_start) begin
      r_state     <= ST_LOAD;
      r_circ_cnt  <= 4'd0;
      r_row_cnt   <= 6'd0;
      r_load_done <= 1'b0;
    end else if (w_accept) begin
      if (w_last_circ) begin
        r_circ_cnt <= 4'd0;
        if (w_last_row) begin
          r_row_cnt   <= 6'd0;
          r_state     <= ST_DONE;
          r_load_done <= 1'b1;
        end else begin
          r_row_cnt <= r_row_cnt + 6'd1;
        end
      end else begin
        r_circ_cnt <= r_circ_cnt + 4'd1;
      end
    end
  end

  // Circulant 0 sits in the MSBs; the last beat bypasses the register.
  always_ff @(posedge clk) begin
    if (w_accept && !w_last_circ) begin
      r_asm[c_ASM_W - 1 - CIRC_SIZE * int'(r_circ_cnt) -: CIRC_SIZE] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_row_wr) begin
      r_mem[r_row_cnt] <= w_full_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (sel < 6'(NUM_ROWS)) begin
      out <= r_mem[sel];
    end else begin
      out <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_g_matrix_row_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_g_matrix_row_loader: directed scoreboard bench for the row loader. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_g_matrix_row_loader;

  localparam int CS = 88;
  localparam int CR = 16;
  localparam int NR = 39;
  localparam int RW = CS * CR;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [CS-1:0] in_data = '0;
  logic          in_ready;
  logic [5:0]    sel = 6'd0;
  logic [RW-1:0] out;
  logic          load_busy;
  logic          load_done;

  int checks = 0;
  int errors = 0;

  logic          rd_req = 1'b0;
  logic          rd_pend = 1'b0;
  logic [RW-1:0] exp_q[$];

  g_matrix_row_loader #(.CIRC_SIZE(CS), .CIRC_PER_ROW(CR), .NUM_ROWS(NR)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .sel(sel), .out(out),
    .load_busy(load_busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  function automatic logic [CS-1:0] pat(input int p, input int r, input int k);
    logic [5:0] r6;
    logic [3:0] k4;
    r6 = r[5:0];
    k4 = k[3:0];
    if (p == 0) return {78'h0, r6, k4};
    return {k4, 8'hC3, 70'h0, r6};
  endfunction

  function automatic logic [RW-1:0] row_exp(input int p, input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int k = 0; k < CR; k++) v[RW-1-CS*k -: CS] = pat(p, r, k);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: a read issued before edge N is compared after edge N.
  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      logic [RW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL readback: output with no expected entry");
      end else begin
        e = exp_q.pop_front();
        if (out !== e) begin
          int fk;
          fk = 0;
          for (int k = CR - 1; k >= 0; k--)
            if (out[RW-1-CS*k -: CS] !== e[RW-1-CS*k -: CS]) fk = k;
          errors++;
          $display("FAIL readback sel=%0d circ %0d: got %0h expected %0h",
                   sel, fk, out[RW-1-CS*fk -: CS], e[RW-1-CS*fk -: CS]);
        end
      end
    end
  end

  task automatic read_row(input int s, input logic [RW-1:0] e);
    sel = 6'(s);
    rd_req = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic start_load(input bit junk_beat);
    load_start = 1'b1;
    in_valid   = junk_beat;
    in_data    = 88'hDEAD_BEEF;
    @(posedge clk); #1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    check("ready_after_start", 32'(in_ready), 32'd1);
  endtask

  task automatic stream(input int p, input int nb, input bit rnd, output int cyc);
    int b;
    bit acc;
    b = 0;
    cyc = 0;
    while (b < nb && cyc < 20000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = pat(p, b / CR, b % CR);
      acc = in_valid && in_ready;
      if (acc && b == NR * CR - 1) check("done_low_before_last", 32'(load_done), 32'd0);
      @(posedge clk); #1;
      cyc++;
      if (acc) b++;
    end
    in_valid = 1'b0;
    if (b < nb) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: got %0d beats required %0d", b, nb);
    end
  endtask

  initial begin
    int cyc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_zero", 32'(out == '0), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full load, valid held high.
    start_load(1'b0);
    stream(0, NR * CR, 1'b0, cyc);
    check("load_cycles", 32'(cyc), 32'd624);
    check("done_after_full", 32'(load_done), 32'd1);
    check("ready_after_full", 32'(in_ready), 32'd0);
    check("busy_after_full", 32'(load_busy), 32'd0);
    for (int r = 0; r < NR; r++) read_row(r, row_exp(0, r));
    read_row(39, '0);
    read_row(63, '0);
    read_row(38, row_exp(0, 38));

    // Full load with gapped valid and a second pattern.
    start_load(1'b0);
    stream(1, NR * CR, 1'b1, cyc);
    check("done_after_gapped", 32'(load_done), 32'd1);
    for (int r = 0; r < NR; r++) read_row(r, row_exp(1, r));

    // Reset after three rows and five beats; partial row 3 is never written.
    start_load(1'b0);
    check("done_cleared_on_start", 32'(load_done), 32'd0);
    stream(0, 3 * CR + 5, 1'b0, cyc);
    check("busy_mid_load", 32'(load_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_busy", 32'(load_busy), 32'd0);
    check("mid_rst_done", 32'(load_done), 32'd0);
    check("mid_rst_out", 32'(out == '0), 32'd1);
    for (int r = 0; r < 3; r++) read_row(r, row_exp(0, r));
    read_row(3, row_exp(1, 3));

    // Restart after 20 beats; the beat offered with the restart is dropped.
    start_load(1'b0);
    stream(0, 20, 1'b0, cyc);
    start_load(1'b1);
    stream(1, NR * CR, 1'b0, cyc);
    check("done_after_restart", 32'(load_done), 32'd1);
    for (int r = 0; r < NR; r++) read_row(r, row_exp(1, r));

    // Read/write collision on row 2.
    start_load(1'b0);
    stream(0, 2 * CR + CR - 1, 1'b0, cyc);
    in_valid = 1'b1;
    in_data  = pat(0, 2, CR - 1);
    read_row(2, row_exp(1, 2));
    in_valid = 1'b0;
    read_row(2, row_exp(0, 2));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
